rrat: RTL and testbench
=======================

Name: rrat

Overview:
- Retirement register alias table. Sits directly downstream of the reorder buffer's commit port.
- Holds the architectural-to-physical register mapping as of the last retired instruction.
- For each retiring instruction with a destination, returns the superseded physical register to the free list.
- Exposes the full committed map so rename can recover on flush.

Parameters:
SS, 2, superscalar width; commit slots per cycle
ARCH_REGS, 32, architectural registers
PHYS_REGS, 64, physical registers (must be > ARCH_REGS)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
commit_valid  input  [SS]  slot i retires this cycle; asserted only when the ROB pops; slots are in program order, slot 0 oldest
commit_rd  input  [SS][$clog2(ARCH_REGS)]  architectural destination of slot i
commit_pd  input  [SS][$clog2(PHYS_REGS)]  physical destination allocated to slot i at rename
commit_regf_we  input  [SS]  slot i writes a register
free_push  output  [SS]  registered; slot i returns a physical register to the free list
free_preg  output  [SS][$clog2(PHYS_REGS)]  register being returned
arch_map  output  [ARCH_REGS][$clog2(PHYS_REGS)]  committed map, read directly from the table registers
retired_count  output  64  total instructions retired since reset

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - arch_map[i] = i for every i.
  - free_push = 0; free_preg = 0; retired_count = 0.
- Effective write: slot i writes when commit_valid[i] && commit_regf_we[i] && commit_rd[i] != 0.
  - x0 is never remapped; arch_map[0] stays 0 permanently.
  - x0 never frees a register.
- Superseded register: old[i] = mapping of commit_rd[i] just before slot i, in program order.
  - old[0] = table[commit_rd[0]].
  - old[1] = commit_pd[0] if slot 0 performs an effective write to the same rd; otherwise table[commit_rd[1]].
  - Generalize for SS > 2 by scanning lower slots; the youngest matching lower slot wins.
- Table update at the clock edge: table[rd] <= commit_pd of the youngest effectively-writing slot targeting that rd.
- Free return, latency 1: in the cycle after commit, free_push[i] = 1 and free_preg[i] = old[i] for each effectively-writing slot; all other slots get free_push = 0 and free_preg = 0.
  - Same-rd pair in one group: slot 1 frees slot 0's commit_pd. Slot 0 frees the prior table value.
  - The free list must accept every push; there is no backpressure. Overflow is a free-list assertion, not handled here.
- retired_count increments by popcount(commit_valid) each cycle. It is 64-bit and wraps modulo 2^64.
- arch_map updates the cycle after commit; there is no same-cycle bypass.
- Flush is handled outside this block. The table is unaffected by flush; commits presented in a flush cycle retire normally.
- Reset mid-stream: rst overrides any commit in the same cycle. Table, outputs and counter take reset values.
- Assertions:
  - commit_valid is a prefix: slot 1 valid implies slot 0 valid.
  - An effectively-writing commit_pd is never 0.
  - No two effective writes in one group share the same commit_pd.

Decomposition:
- Shared package: ARCH_REG_IDX_W and PHYS_REG_IDX_W constants, and a typedef for the per-slot commit fields.
- The ROB-facing wrapper extracts these fields from the dispatch record.
- No sub-module. Old-mapping resolution is a small combinational priority loop inside rrat.

Test Plan:
- Reset then idle: arch_map[5] = 5, free_push = 00, retired_count = 0.
- Single commit, slot 0: rd = 5, pd = 40, valid = 01 -> next cycle arch_map[5] = 40, free_push = 01, free_preg[0] = 5, retired_count = 1.
- Dual commit to the same rd: rd = 7/7, pd = 41/42 -> arch_map[7] = 42, free_preg = {7, 41}, free_push = 11, retired_count = +2.
- Dual commit with x0 and a non-writing slot: slot 0 rd = 0, pd = 50; slot 1 regf_we = 0 -> arch_map unchanged, free_push = 00, retired_count = +2.
- Chained across cycles: rd = 3 pd = 33, then rd = 3 pd = 34 -> second return frees 33; arch_map[3] = 34.
- Reset asserted alongside a valid commit (rd = 9, pd = 45) -> arch_map[9] = 9, free_push = 00, retired_count = 0.

Source files
------------

// File: rtl/rrat_pkg.sv
// Retirement RAT shared types and sizing.
// Commit slot fields are extracted by the ROB-facing wrapper.
package rrat_pkg;

    localparam int SS_DEF        = 2;
    localparam int ARCH_REGS_DEF = 32;
    localparam int PHYS_REGS_DEF = 64;

    localparam int ARCH_REG_IDX_W = $clog2(ARCH_REGS_DEF);
    localparam int PHYS_REG_IDX_W = $clog2(PHYS_REGS_DEF);

    typedef struct packed {
        logic                      valid;
        logic                      regf_we;
        logic [ARCH_REG_IDX_W-1:0] rd;
        logic [PHYS_REG_IDX_W-1:0] pd;
    } commit_slot_t;

endpackage

// File: rtl/rrat_if.sv
// Commit-in / free-out bundle between ROB, RRAT and free list.
// The ROB side is the master; the RRAT is the slave.
interface rrat_if #(
    parameter int SS = 2,
    parameter int AW = 5,
    parameter int PW = 6
);

    logic [SS-1:0]         commit_valid;
    logic [SS-1:0][AW-1:0] commit_rd;
    logic [SS-1:0][PW-1:0] commit_pd;
    logic [SS-1:0]         commit_regf_we;
    logic [SS-1:0]         free_push;
    logic [SS-1:0][PW-1:0] free_preg;

    modport master (
        output commit_valid, commit_rd, commit_pd, commit_regf_we,
        input  free_push, free_preg
    );

    modport slave (
        input  commit_valid, commit_rd, commit_pd, commit_regf_we,
        output free_push, free_preg
    );

endinterface

// File: rtl/rrat.sv
// Retirement register alias table: committed arch->phys map,
// returns superseded physical registers to the free list.
module rrat
    import rrat_pkg::*;
#(
    parameter int SS        = SS_DEF,
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int PHYS_REGS = PHYS_REGS_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    rrat_if.slave                                    cm,
    output logic [ARCH_REGS-1:0][$clog2(PHYS_REGS)-1:0] arch_map,
    output logic [63:0]                              retired_count
);

    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);

    logic [SS-1:0]                eff;
    logic [SS-1:0][PW-1:0]        old;
    logic [ARCH_REGS-1:0][PW-1:0] nxt;
    logic [63:0]                  cnt;

    always_comb begin
        eff = '0;
        old = '0;
        nxt = arch_map;
        cnt = '0;
        for (int i = 0; i < SS; i++) begin
            eff[i] = cm.commit_valid[i] && cm.commit_regf_we[i]
                     && (cm.commit_rd[i] != '0);
            cnt    = cnt + 64'(cm.commit_valid[i]);
        end
        // Older slots in the same group shadow the table; youngest wins.
        for (int i = 0; i < SS; i++) begin
            old[i] = arch_map[cm.commit_rd[i]];
            for (int j = 0; j < i; j++) begin
                if (eff[j] && cm.commit_rd[j] == cm.commit_rd[i])
                    old[i] = cm.commit_pd[j];
            end
        end
        for (int i = 0; i < SS; i++) begin
            if (eff[i])
                nxt[cm.commit_rd[i]] = cm.commit_pd[i];
        end
        nxt[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                arch_map[i] <= PW'(i);
            cm.free_push  <= '0;
            cm.free_preg  <= '0;
            retired_count <= '0;
        end else begin
            arch_map      <= nxt;
            cm.free_push  <= eff;
            for (int i = 0; i < SS; i++)
                cm.free_preg[i] <= eff[i] ? old[i] : '0;
            retired_count <= retired_count + cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < SS; i++)
                assert (!cm.commit_valid[i] || cm.commit_valid[i-1]);
            for (int i = 0; i < SS; i++) begin
                assert (!eff[i] || cm.commit_pd[i] != '0);
                for (int j = 0; j < i; j++)
                    assert (!(eff[i] && eff[j]
                              && cm.commit_pd[i] == cm.commit_pd[j]));
            end
        end
    end

endmodule

// File: tb/tb_rrat.sv
// Directed-vector self-checking bench for rrat.
module tb_rrat;

    logic clk;
    logic rst;
    logic [31:0][5:0] arch_map;
    logic [63:0] retired_count;
    int checks;
    int errors;

    rrat_if #(.SS(2), .AW(5), .PW(6)) bus ();

    rrat dut (
        .clk           (clk),
        .rst           (rst),
        .cm            (bus),
        .arch_map      (arch_map),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.commit_valid   = '0;
        bus.commit_rd      = '0;
        bus.commit_pd      = '0;
        bus.commit_regf_we = '0;
    endtask

    // Present one commit group for one edge, then go idle.
    task automatic commit(input logic [1:0] v, input logic [1:0] we,
                          input logic [4:0] rd0, input logic [5:0] pd0,
                          input logic [4:0] rd1, input logic [5:0] pd1);
        bus.commit_valid   = v;
        bus.commit_regf_we = we;
        bus.commit_rd[0]   = rd0;
        bus.commit_pd[0]   = pd0;
        bus.commit_rd[1]   = rd1;
        bus.commit_pd[1]   = pd1;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_map5", 64'(arch_map[5]), 64'd5);
        chk("rst_map0", 64'(arch_map[0]), 64'd0);
        chk("rst_push", 64'(bus.free_push), 64'd0);
        chk("rst_cnt", retired_count, 64'd0);

        commit(2'b01, 2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
        chk("s0_map5", 64'(arch_map[5]), 64'd40);
        chk("s0_push", 64'(bus.free_push), 64'd1);
        chk("s0_preg0", 64'(bus.free_preg[0]), 64'd5);
        chk("s0_preg1", 64'(bus.free_preg[1]), 64'd0);
        chk("s0_cnt", retired_count, 64'd1);

        commit(2'b11, 2'b11, 5'd7, 6'd41, 5'd7, 6'd42);
        chk("same_map7", 64'(arch_map[7]), 64'd42);
        chk("same_push", 64'(bus.free_push), 64'd3);
        chk("same_preg0", 64'(bus.free_preg[0]), 64'd7);
        chk("same_preg1", 64'(bus.free_preg[1]), 64'd41);
        chk("same_cnt", retired_count, 64'd3);

        commit(2'b11, 2'b01, 5'd0, 6'd50, 5'd4, 6'd51);
        chk("x0_push", 64'(bus.free_push), 64'd0);
        chk("x0_preg0", 64'(bus.free_preg[0]), 64'd0);
        chk("x0_map0", 64'(arch_map[0]), 64'd0);
        chk("x0_map4", 64'(arch_map[4]), 64'd4);
        chk("x0_cnt", retired_count, 64'd5);

        commit(2'b01, 2'b01, 5'd3, 6'd33, 5'd0, 6'd0);
        chk("ch1_preg0", 64'(bus.free_preg[0]), 64'd3);
        commit(2'b01, 2'b01, 5'd3, 6'd34, 5'd0, 6'd0);
        chk("ch2_preg0", 64'(bus.free_preg[0]), 64'd33);
        chk("ch2_map3", 64'(arch_map[3]), 64'd34);
        chk("ch2_cnt", retired_count, 64'd7);

        commit(2'b11, 2'b11, 5'd10, 6'd60, 5'd11, 6'd61);
        chk("diff_preg0", 64'(bus.free_preg[0]), 64'd10);
        chk("diff_preg1", 64'(bus.free_preg[1]), 64'd11);
        chk("diff_map10", 64'(arch_map[10]), 64'd60);
        chk("diff_map11", 64'(arch_map[11]), 64'd61);
        chk("diff_cnt", retired_count, 64'd9);

        @(posedge clk);
        #1;
        chk("idle_push", 64'(bus.free_push), 64'd0);
        chk("idle_map7", 64'(arch_map[7]), 64'd42);
        chk("idle_cnt", retired_count, 64'd9);

        rst = 1'b1;
        commit(2'b01, 2'b01, 5'd9, 6'd45, 5'd0, 6'd0);
        rst = 1'b0;
        chk("rc_map9", 64'(arch_map[9]), 64'd9);
        chk("rc_map5", 64'(arch_map[5]), 64'd5);
        chk("rc_push", 64'(bus.free_push), 64'd0);
        chk("rc_cnt", retired_count, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
